reg_bank32: RTL and testbench

- Architectural integer register storage for the RISCV datapath: 32 x 32-bit registers.
- Sits directly upstream of the mux32x1 read-port selectors. Drives all 32 register values in parallel on q0..q31; each read port's mux32x1 picks one by rs address.
- Single synchronous write port from writeback.
- Per-register busy scoreboard: the issue stage flags registers awaiting a multi-cycle result, and hazard logic stalls on them.

---
 rtl/rv_pkg.sv | 17 +
 rtl/reg_bank32_decoder5x32.sv | 18 +
 rtl/reg_bank32.sv | 132 +++++++++++++
 tb/tb_reg_bank32.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types and sizes for the integer datapath.
// Imported by the register bank and its decoders.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NREG-1:0]       reg_mask_t;

    function automatic logic is_x0(input reg_addr_t a);
        return a == '0;
    endfunction

endpackage

// File: rtl/reg_bank32_decoder5x32.sv
// 5-to-32 one-hot decoder with enable.
// All outputs are low when en is low.
module decoder5x32
    import rv_pkg::*;
(
    input  logic      en,
    input  reg_addr_t a,
    output reg_mask_t y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank32.sv
// 32 x XLEN architectural register file with busy scoreboard
// and a wrapping count of committed writes.
module reg_bank32
    import rv_pkg::*;
#(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  reg_addr_t   waddr,
    input  word_t       wdata,
    input  logic        mark_en,
    input  reg_addr_t   mark_addr,
    output word_t       q0,
    output word_t       q1,
    output word_t       q2,
    output word_t       q3,
    output word_t       q4,
    output word_t       q5,
    output word_t       q6,
    output word_t       q7,
    output word_t       q8,
    output word_t       q9,
    output word_t       q10,
    output word_t       q11,
    output word_t       q12,
    output word_t       q13,
    output word_t       q14,
    output word_t       q15,
    output word_t       q16,
    output word_t       q17,
    output word_t       q18,
    output word_t       q19,
    output word_t       q20,
    output word_t       q21,
    output word_t       q22,
    output word_t       q23,
    output word_t       q24,
    output word_t       q25,
    output word_t       q26,
    output word_t       q27,
    output word_t       q28,
    output word_t       q29,
    output word_t       q30,
    output word_t       q31,
    output logic [31:0] busy,
    output logic [15:0] wr_count
);

    word_t     regs [NREG];
    reg_mask_t busy_r;
    reg_mask_t wr_oh;
    reg_mask_t mk_oh;
    logic      wr_ok;
    logic      mk_ok;

    // Index 0 is filtered before decode so discarded writes never count.
    assign wr_ok = we && !(ZERO_REG && is_x0(waddr));
    assign mk_ok = mark_en && !(ZERO_REG && is_x0(mark_addr));

    decoder5x32 u_wr_dec (
        .en (wr_ok),
        .a  (waddr),
        .y  (wr_oh)
    );

    decoder5x32 u_mk_dec (
        .en (mk_ok),
        .a  (mark_addr),
        .y  (mk_oh)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy_r   <= '0;
            wr_count <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_oh[i]) begin
                    regs[i] <= wdata;
                end
                // A fresh mark supersedes the retiring producer.
                if (mk_oh[i]) begin
                    busy_r[i] <= 1'b1;
                end else if (wr_oh[i]) begin
                    busy_r[i] <= 1'b0;
                end
            end
            wr_count <= wr_count + {15'd0, wr_ok};
        end
    end

    assign busy = ZERO_REG ? {busy_r[NREG-1:1], 1'b0} : busy_r;

    assign q0  = ZERO_REG ? '0 : regs[0];
    assign q1  = regs[1];
    assign q2  = regs[2];
    assign q3  = regs[3];
    assign q4  = regs[4];
    assign q5  = regs[5];
    assign q6  = regs[6];
    assign q7  = regs[7];
    assign q8  = regs[8];
    assign q9  = regs[9];
    assign q10 = regs[10];
    assign q11 = regs[11];
    assign q12 = regs[12];
    assign q13 = regs[13];
    assign q14 = regs[14];
    assign q15 = regs[15];
    assign q16 = regs[16];
    assign q17 = regs[17];
    assign q18 = regs[18];
    assign q19 = regs[19];
    assign q20 = regs[20];
    assign q21 = regs[21];
    assign q22 = regs[22];
    assign q23 = regs[23];
    assign q24 = regs[24];
    assign q25 = regs[25];
    assign q26 = regs[26];
    assign q27 = regs[27];
    assign q28 = regs[28];
    assign q29 = regs[29];
    assign q30 = regs[30];
    assign q31 = regs[31];

endmodule

// File: tb/tb_reg_bank32.sv
// Directed self-checking bench for reg_bank32.
// Vector table plus hand sequences for reset, x0 and wrap.
module tb_reg_bank32;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    reg_addr_t   waddr;
    word_t       wdata;
    logic        mark_en;
    reg_addr_t   mark_addr;
    word_t       q0, q1, q2, q3, q4, q5, q6, q7;
    word_t       q8, q9, q10, q11, q12, q13, q14, q15;
    word_t       q16, q17, q18, q19, q20, q21, q22, q23;
    word_t       q24, q25, q26, q27, q28, q29, q30, q31;
    logic [31:0] busy;
    logic [15:0] wr_count;
    logic [32*32-1:0] qflat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_bank32 #(.ZERO_REG(1'b1)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .mark_en(mark_en), .mark_addr(mark_addr),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .q4(q4), .q5(q5), .q6(q6), .q7(q7),
        .q8(q8), .q9(q9), .q10(q10), .q11(q11),
        .q12(q12), .q13(q13), .q14(q14), .q15(q15),
        .q16(q16), .q17(q17), .q18(q18), .q19(q19),
        .q20(q20), .q21(q21), .q22(q22), .q23(q23),
        .q24(q24), .q25(q25), .q26(q26), .q27(q27),
        .q28(q28), .q29(q29), .q30(q30), .q31(q31),
        .busy(busy), .wr_count(wr_count)
    );

    assign qflat = {q31, q30, q29, q28, q27, q26, q25, q24,
                    q23, q22, q21, q20, q19, q18, q17, q16,
                    q15, q14, q13, q12, q11, q10, q9, q8,
                    q7, q6, q5, q4, q3, q2, q1, q0};

    // Stand-in for a downstream mux32x1 read port.
    function automatic word_t mux32(input logic [4:0] sl);
        return qflat[sl*32 +: 32];
    endfunction

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mark_en;
        logic [4:0]  mark_addr;
        logic [4:0]  idx;
        logic [31:0] exp_q;
        logic [31:0] exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 1'b0; waddr = '0; wdata = '0;
        mark_en = 1'b0; mark_addr = '0;
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s q%0d", tag, i), mux32(5'(i)), 32'h0);
        end
        check({tag, " busy"}, busy, 32'h0);
        check({tag, " cnt"}, {16'h0, wr_count}, 32'h0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0,
                    5'd0, 32'h0, 32'h0, 16'd31};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd5,
                    5'd5, 32'h105, 32'h20, 16'd31};
        vecs[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    5'd5, 32'h105, 32'h20, 16'd31};
        vecs[3] = '{1'b1, 5'd5, 32'hA5, 1'b0, 5'd0,
                    5'd5, 32'hA5, 32'h0, 16'd32};
        vecs[4] = '{1'b1, 5'd7, 32'h77, 1'b1, 5'd7,
                    5'd7, 32'h77, 32'h80, 16'd33};
        vecs[5] = '{1'b1, 5'd9, 32'h99, 1'b1, 5'd3,
                    5'd9, 32'h99, 32'h88, 16'd34};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0,
                    5'd0, 32'h0, 32'h88, 16'd34};
        vecs[7] = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd0,
                    5'd3, 32'h33, 32'h80, 16'd35};
        vecs[8] = '{1'b1, 5'd7, 32'h7070, 1'b1, 5'd3,
                    5'd7, 32'h7070, 32'h08, 16'd36};

        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;

        // Preload some state, then reset with we/mark active.
        we = 1'b1; waddr = 5'd4; wdata = 32'h1234;
        mark_en = 1'b1; mark_addr = 5'd6;
        step();
        check("preload q4", q4, 32'h1234);
        check("preload busy", busy, 32'h40);
        rst = 1'b1;
        waddr = 5'd2; wdata = 32'h55; mark_addr = 5'd8;
        step();
        rst = 1'b0;
        idle_inputs();
        check_cleared("rst1");

        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = 5'(i); wdata = 32'h100 + i;
            step();
            check($sformatf("wr q%0d", i), mux32(5'(i)), 32'h100 + i);
            check($sformatf("wr cnt%0d", i), {16'h0, wr_count}, i);
        end
        idle_inputs();

        for (int v = 0; v < 9; v++) begin
            we = vecs[v].we; waddr = vecs[v].waddr;
            wdata = vecs[v].wdata;
            mark_en = vecs[v].mark_en; mark_addr = vecs[v].mark_addr;
            step();
            check($sformatf("vec%0d q", v), mux32(vecs[v].idx),
                  vecs[v].exp_q);
            check($sformatf("vec%0d busy", v), busy, vecs[v].exp_busy);
            check($sformatf("vec%0d cnt", v), {16'h0, wr_count},
                  {16'h0, vecs[v].exp_cnt});
        end
        idle_inputs();
        step();

        check("mux sl0", mux32(5'd0), 32'h0);
        check("mux sl1", mux32(5'd1), 32'h101);
        check("mux sl2", mux32(5'd2), 32'h102);
        check("mux sl3", mux32(5'd3), 32'h33);
        check("mux sl4", mux32(5'd4), 32'h104);
        check("q9 hold", q9, 32'h99);

        // Reset dominance over a live write and mark.
        rst = 1'b1;
        we = 1'b1; waddr = 5'd10; wdata = 32'hCAFE;
        mark_en = 1'b1; mark_addr = 5'd11;
        step();
        rst = 1'b0;
        idle_inputs();
        check_cleared("rst2");

        we = 1'b1; waddr = 5'd1;
        for (int n = 1; n <= 65534; n++) begin
            wdata = n;
            step();
        end
        check("wrap pre", {16'h0, wr_count}, 32'h0000FFFE);
        wdata = 32'hFFFF;
        step();
        check("wrap ffff", {16'h0, wr_count}, 32'h0000FFFF);
        wdata = 32'h10000;
        step();
        check("wrap zero", {16'h0, wr_count}, 32'h0);
        check("wrap q1", q1, 32'h10000);
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
